// File: rtl/dma_tx_engine.sv
// -----------------------------------------------------------------------------
// dma_tx_engine
// Transmit-side DMA. A CPU send command makes the engine request the RAM bus,
// read two bytes (MSB at BASE_ADDR, LSB at BASE_ADDR+1) and release the bus.
// It then hands the bytes, MSB first, to the UART transmitter using a
// Valid_D / Ack_in handshake.
//
// Optional feature, macro DMA_TX_TIMEOUT_EN:
//   With the macro defined, a watchdog counts the cycles in which Valid_D is
//   high and clears on every Ack_in. When the count reaches TIMEOUT_CYCLES the
//   engine drops Valid_D, pulses Tx_err for one cycle and returns to IDLE.
//   Any byte not yet sent is dropped.
//   With the macro undefined there is no counter and Tx_err is tied to 0.
//
// Ports
//   Clk        in   1  system clock, rising edge
//   Rst        in   1  synchronous active-high reset
//   Send_comm  in   1  one-cycle start request from CPU (honoured in IDLE only)
//   Ready      out  1  high only in IDLE
//   Dma_rq     out  1  RAM bus request
//   Dma_ack    in   1  RAM bus grant
//   Address    out  8  RAM read address (meaningful while OE=1, else 0)
//   OE         out  1  RAM read enable
//   Databus    in   8  RAM read data, valid the cycle after OE=1
//   TX_data    out  8  byte presented to the UART
//   Valid_D    out  1  TX_data valid
//   Ack_in     in   1  UART accepted TX_data
//   TX_RDY     in   1  UART idle, able to take a byte
//   Tx_err     out  1  one-cycle watchdog abort pulse
// -----------------------------------------------------------------------------
module dma_tx_engine #(
   parameter logic [7:0] BASE_ADDR      = 8'h04,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Send_comm,
   output logic       Ready,
   output logic       Dma_rq,
   input  logic       Dma_ack,
   output logic [7:0] Address,
   output logic       OE,
   input  logic [7:0] Databus,
   output logic [7:0] TX_data,
   output logic       Valid_D,
   input  logic       Ack_in,
   input  logic       TX_RDY,
   output logic       Tx_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RD_MSB,
      S_RD_LSB,
      S_CAP_LSB,
      S_SEND_MSB,
      S_SEND_LSB
   } state_t;

   localparam logic [7:0] LSB_ADDR = BASE_ADDR + 8'd1;   // wraps 0xFF -> 0x00

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_msb;
   logic [7:0] r_lsb;
   logic       r_valid;
   logic       w_sending;
   logic       w_ack;
   logic       w_tout;

   assign w_sending = (r_state == S_SEND_MSB) || (r_state == S_SEND_LSB);
   // An Ack_in counts only while the byte is actually being offered.
   assign w_ack     = w_sending && r_valid && Ack_in;

`ifdef DMA_TX_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic          r_err;

   // r_cnt holds the number of Valid_D cycles already elapsed. The cycle in
   // which it equals TIMEOUT_CYCLES-1 is the last permitted Valid_D cycle.
   assign w_tout = r_valid && !Ack_in && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign Tx_err = r_err;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_tout;
         if (!r_valid || Ack_in || w_tout) r_cnt <= '0;
         else                              r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   logic w_unused_tout;

   assign w_unused_tout = (TIMEOUT_CYCLES > 0);
   assign w_tout        = 1'b0;
   assign Tx_err        = 1'b0;
`endif

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next state and state-decoded outputs
   always_comb begin
      w_next  = r_state;
      Ready   = 1'b0;
      Dma_rq  = 1'b0;
      OE      = 1'b0;
      Address = 8'h00;
      TX_data = 8'h00;
      case (r_state)
         S_IDLE: begin
            Ready = 1'b1;
            if (Send_comm) w_next = S_REQ;
         end
         S_REQ: begin
            Dma_rq = 1'b1;
            if (Dma_ack) w_next = S_RD_MSB;
         end
         // Losing the grant during any read step restarts from the MSB.
         S_RD_MSB: begin
            Dma_rq  = 1'b1;
            OE      = 1'b1;
            Address = BASE_ADDR;
            w_next  = Dma_ack ? S_RD_LSB : S_REQ;
         end
         S_RD_LSB: begin
            Dma_rq  = 1'b1;
            OE      = 1'b1;
            Address = LSB_ADDR;
            w_next  = Dma_ack ? S_CAP_LSB : S_REQ;
         end
         S_CAP_LSB: begin
            Dma_rq = 1'b1;
            w_next = Dma_ack ? S_SEND_MSB : S_REQ;
         end
         S_SEND_MSB: begin
            TX_data = r_msb;
            if (w_tout)     w_next = S_IDLE;
            else if (w_ack) w_next = S_SEND_LSB;
         end
         S_SEND_LSB: begin
            TX_data = r_lsb;
            if (w_tout || w_ack) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Byte capture: RAM data lags OE by one cycle.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_msb <= 8'h00;
         r_lsb <= 8'h00;
      end else begin
         if (r_state == S_RD_LSB  && Dma_ack) r_msb <= Databus;
         if (r_state == S_CAP_LSB && Dma_ack) r_lsb <= Databus;
      end
   end

   // Valid_D: raised from a sampled TX_RDY=1 and held until accepted. After
   // the MSB ack it falls for at least one cycle before the LSB is offered.
   // Leaving CAP_LSB it is pre-armed so the MSB is valid on SEND_MSB entry.
   always_ff @(posedge Clk) begin
      if (Rst)                                             r_valid <= 1'b0;
      else if (w_ack || w_tout)                            r_valid <= 1'b0;
      else if (r_state == S_CAP_LSB && Dma_ack && TX_RDY)  r_valid <= 1'b1;
      else if (w_sending && !r_valid && TX_RDY)            r_valid <= 1'b1;
   end

   assign Valid_D = r_valid;

endmodule

// File: tb/tb_dma_tx_engine.sv
module tb_dma_tx_engine;

   localparam logic [7:0] BASE  = 8'h04;
   localparam logic [7:0] BASE1 = BASE + 8'd1;

   logic       Clk, Rst, Send_comm, Ready, Dma_rq, Dma_ack, OE;
   logic       Valid_D, Ack_in, TX_RDY, Tx_err;
   logic [7:0] Address, Databus, TX_data;

   dma_tx_engine #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(16)) dut (
      .Clk(Clk), .Rst(Rst), .Send_comm(Send_comm), .Ready(Ready),
      .Dma_rq(Dma_rq), .Dma_ack(Dma_ack), .Address(Address), .OE(OE),
      .Databus(Databus), .TX_data(TX_data), .Valid_D(Valid_D),
      .Ack_in(Ack_in), .TX_RDY(TX_RDY), .Tx_err(Tx_err)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // RAM model: registered read, data valid the cycle after the address.
   logic [7:0] ram [256];
   always @(posedge Clk) Databus <= ram[Address];

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Environment state (bus arbiter + UART model + monitor)
   int         gnt_hold = 0, rdy_low = 0, ack_lat = 1, vcnt = 0, rq_cnt = 0;
   bit         drop_req = 0, spur = 0, pv = 0, pa = 0;
   logic [7:0] pd = 8'h00;
   logic [7:0] got_q[$];
   logic [7:0] addr_q[$];

   task automatic tick();
      @(posedge Clk);
      #1;
      // UART-side properties
      if (pv && Valid_D && !pa) chk("hold_data", TX_data, pd);
      if (pv && pa)             chk("gap_after_ack", Valid_D, 1'b0);
`ifndef DMA_TX_TIMEOUT_EN
      if (Tx_err)               chk("tx_err_tied", Tx_err, 1'b0);
`endif
      if (OE)     addr_q.push_back(Address);
      if (Dma_rq) rq_cnt++;
      // bus arbiter
      if (gnt_hold > 0) begin
         Dma_ack = 1'b0;
         gnt_hold--;
      end else if (drop_req && OE && Address == BASE1) begin
         Dma_ack  = 1'b0;
         drop_req = 0;
      end else Dma_ack = 1'b1;
      // UART
      if (rdy_low > 0) begin
         TX_RDY = 1'b0;
         rdy_low--;
      end else TX_RDY = 1'b1;
      if (Valid_D) begin
         vcnt++;
         Ack_in = (ack_lat >= 0) && (vcnt == ack_lat + 1);
      end else begin
         vcnt   = 0;
         Ack_in = spur && ($urandom_range(0, 3) == 0);
      end
      if (Valid_D && Ack_in) got_q.push_back(TX_data);
      pv = Valid_D;
      pa = Ack_in;
      pd = TX_data;
   endtask

   // Wait for the transfer to end and compare the UART bytes to RAM.
   task automatic finish_xfer(input string tag, input bit ovl);
      logic [7:0] e0, e1;
      e0 = ram[BASE];
      e1 = ram[BASE1];
      for (int i = 0; i < 400 && !Ready; i++) begin
         Send_comm = ovl && (i == 2 || i == 6 || i == 9);
         tick();
      end
      Send_comm = 1'b0;
      chk({tag, "_ready"}, Ready, 1'b1);
      chk({tag, "_nbytes"}, got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk({tag, "_msb"}, got_q[0], e0);
         chk({tag, "_lsb"}, got_q[1], e1);
      end
   endtask

   task automatic start();
      got_q.delete();
      addr_q.delete();
      rq_cnt    = 0;
      Send_comm = 1'b1;
      tick();
      Send_comm = 1'b0;
   endtask

   bit rq_a[16], oe_a[16], vd_a[16], rd_a[16];
   bit flag;
   int vc;

   initial begin
      Rst = 1'b1; Send_comm = 1'b0; Dma_ack = 1'b1; TX_RDY = 1'b1; Ack_in = 1'b0;
      for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);

      // Reset
      tick(); tick();
      chk("rst_ready", Ready, 1'b1);
      chk("rst_dma_rq", Dma_rq, 1'b0);
      chk("rst_oe", OE, 1'b0);
      chk("rst_addr", Address, 8'h00);
      chk("rst_valid", Valid_D, 1'b0);
      chk("rst_txdata", TX_data, 8'h00);
      chk("rst_txerr", Tx_err, 1'b0);
      Rst = 1'b0;
      tick();

      // Basic send with cycle-exact latency
      ram[BASE] = 8'hA5; ram[BASE1] = 8'h3C;
      got_q.delete(); addr_q.delete(); rq_cnt = 0;
      Send_comm = 1'b1;
      for (int k = 1; k < 16; k++) begin
         tick();
         Send_comm = 1'b0;
         rq_a[k] = Dma_rq; oe_a[k] = OE; vd_a[k] = Valid_D; rd_a[k] = Ready;
      end
      chk("lat_rq_c1", rq_a[1], 1'b1);
      chk("lat_oe_c1", oe_a[1], 1'b0);
      chk("lat_oe_c2", oe_a[2], 1'b1);
      chk("lat_oe_c3", oe_a[3], 1'b1);
      chk("lat_oe_c4", oe_a[4], 1'b0);
      chk("lat_vd_c4", vd_a[4], 1'b0);
      chk("lat_vd_c5", vd_a[5], 1'b1);
      chk("lat_rq_c5", rq_a[5], 1'b0);
      chk("lat_rdy_c9", rd_a[9], 1'b0);
      chk("lat_rdy_c10", rd_a[10], 1'b1);
      chk("basic_rq_cycles", rq_cnt, 4);
      chk("basic_nbytes", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("basic_msb", got_q[0], 8'hA5);
         chk("basic_lsb", got_q[1], 8'h3C);
      end
      chk("basic_nreads", addr_q.size(), 2);
      if (addr_q.size() == 2) begin
         chk("basic_addr0", addr_q[0], BASE);
         chk("basic_addr1", addr_q[1], BASE1);
      end

      // Grant delay: bus held back 10+ cycles
      ram[BASE] = 8'($urandom); ram[BASE1] = 8'($urandom);
      gnt_hold = 11;
      start();
      flag = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (!(Dma_rq && !OE)) flag = 0;
      end
      chk("gdelay_rq_hold_no_oe", flag, 1'b1);
      finish_xfer("gdelay", 0);

      // Grant loss during the LSB read
      ram[BASE] = 8'hA5; ram[BASE1] = 8'h3C;
      drop_req = 1;
      start();
      finish_xfer("gloss", 0);
      chk("gloss_nreads", addr_q.size(), 4);
      if (addr_q.size() == 4) begin
         chk("gloss_a0", addr_q[0], BASE);
         chk("gloss_a1", addr_q[1], BASE1);
         chk("gloss_a2", addr_q[2], BASE);
         chk("gloss_a3", addr_q[3], BASE1);
      end

      // UART backpressure: not ready 20 cycles, then slow ack
      ram[BASE] = 8'($urandom); ram[BASE1] = 8'($urandom);
      rdy_low = 20; ack_lat = 7;
      start();
      flag = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (Valid_D) flag = 0;
      end
      chk("bp_valid_low", flag, 1'b1);
      finish_xfer("bp", 0);
      ack_lat = 1;

      // Repeated Send_comm during a transfer
      ram[BASE] = 8'($urandom); ram[BASE1] = 8'($urandom);
      start();
      finish_xfer("ovl", 1);
      flag = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (Dma_rq || !Ready) flag = 0;
      end
      chk("ovl_no_requeue", flag, 1'b1);

      // Randomized transfers
      spur = 1;
      for (int n = 0; n < 40; n++) begin
         ram[BASE] = 8'($urandom); ram[BASE1] = 8'($urandom);
         gnt_hold = $urandom_range(0, 4);
         drop_req = ($urandom_range(0, 2) == 0);
         rdy_low  = $urandom_range(0, 5);
         ack_lat  = $urandom_range(0, 4);
         start();
         finish_xfer($sformatf("rnd%0d", n), 0);
         for (int k = 0; k < $urandom_range(0, 3); k++) tick();
      end
      spur = 0; ack_lat = 1; drop_req = 0;

      // Reset while the MSB is on offer
      ack_lat = -1;
      start();
      for (int k = 0; k < 50 && !Valid_D; k++) tick();
      chk("rstmid_saw_valid", Valid_D, 1'b1);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      chk("rstmid_ready", Ready, 1'b1);
      chk("rstmid_valid", Valid_D, 1'b0);
      chk("rstmid_txdata", TX_data, 8'h00);
      flag = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (Valid_D || Dma_rq) flag = 0;
      end
      chk("rstmid_quiet", flag, 1'b1);
      chk("rstmid_nbytes", got_q.size(), 0);

`ifdef DMA_TX_TIMEOUT_EN
      // Watchdog: ack never comes
      start();
      vc = 0;
      for (int k = 0; k < 100 && !Tx_err; k++) begin
         tick();
         if (Valid_D) vc++;
      end
      chk("tout_valid_cycles", vc, 16);
      chk("tout_err", Tx_err, 1'b1);
      chk("tout_ready", Ready, 1'b1);
      chk("tout_valid_off", Valid_D, 1'b0);
      tick();
      chk("tout_err_pulse", Tx_err, 1'b0);
      chk("tout_nbytes", got_q.size(), 0);
`endif
      ack_lat = 1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
